dmem_arbiter: RTL and testbench

- Shares the single-ported unified byte memory (8-bit byte address, 32-bit data, funct3-sized accesses) between two requesters: instruction fetch (IF) and the load/store unit (D).
- Sits between the core and the memory block.
- Serialises accesses through a three-state FSM, latches each granted request and returns registered read data with a one-cycle ready pulse.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed memory port between instruction fetch and load/store.
// Optional DMEM_ARB_ROUND_ROBIN_EN alternates grants under contention; default is D over IF.
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [2:0]    mem_funct3,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_D   = 1'b1;
  localparam logic [2:0] F3_WORD = 3'b010;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          grant_d_c;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  // Under contention the side that lost the previous grant wins.
  assign grant_d_c = d_req && (!if_req || (last_owner_q == OWN_IF));
`else
  assign grant_d_c = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      wdata_q     <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ACCESS;
          if (grant_d_c) begin
            owner_d  = OWN_D;
            addr_d   = d_addr;
            we_d     = d_we;
            funct3_d = d_funct3;
            wdata_d  = d_wdata;
          end else begin
            owner_d  = OWN_IF;
            addr_d   = if_addr;
            we_d     = 1'b0;
            funct3_d = F3_WORD;
            wdata_d  = '0;
          end
          // Strobes are registered so they line up with the ACCESS cycle.
          mem_read_d  = !(grant_d_c && d_we);
          mem_write_d = grant_d_c && d_we;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_owner_d = grant_d_c ? OWN_D : OWN_IF;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == OWN_D) begin
          d_ready_d = 1'b1;
          if (!we_q) d_rdata_d = mem_rdata;
        end else begin
          if_ready_d = 1'b1;
          if (!we_q) if_rdata_d = mem_rdata;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_ready   = if_ready_q;
  assign d_ready    = d_ready_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_addr   = addr_q;
  assign mem_funct3 = funct3_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors, corner sequences and a randomized run against a transaction model.
// Expectations follow DMEM_ARB_ROUND_ROBIN_EN when the build defines it.
module tb_dmem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ready, d_req, d_we, d_ready, mem_read, mem_write;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [2:0]    d_funct3, mem_funct3;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem  [256];
  logic [7:0] gold [256];

  function automatic logic [7:0] init_byte(input int i);
    if (i == 0) return 8'd12;
    if (i < 4) return 8'd0;
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [31:0] ld(input logic [7:0] b0, b1, b2, b3, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ld_gold(input logic [7:0] a, input logic [2:0] f3);
    return ld(gold[a], gold[8'(a + 8'd1)], gold[8'(a + 8'd2)], gold[8'(a + 8'd3)], f3);
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  // Behavioural memory: combinational read, write at the clock edge.
  assign mem_rdata = ld(mem[mem_addr], mem[8'(mem_addr + 8'd1)], mem[8'(mem_addr + 8'd2)],
                        mem[8'(mem_addr + 8'd3)], mem_funct3);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_write) begin
        case (mem_funct3)
          3'b000: mem[mem_addr] = mem_wdata[7:0];
          3'b001: begin mem[mem_addr] = mem_wdata[7:0]; mem[8'(mem_addr + 8'd1)] = mem_wdata[15:8]; end
          3'b010: for (int k = 0; k < 4; k++) mem[8'(mem_addr + 8'(k))] = 8'(mem_wdata >> (8 * k));
          default: ;
        endcase
      end
    end
  end

  task automatic st_gold(input logic [7:0] a, input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000: gold[a] = v[7:0];
      3'b001: begin gold[a] = v[7:0]; gold[8'(a + 8'd1)] = v[15:8]; end
      3'b010: for (int k = 0; k < 4; k++) gold[8'(a + 8'(k))] = 8'(v >> (8 * k));
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_txn(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    lat = 0;
    while (!d_ready && lat < 10) begin
      step();
      lat++;
      if (lat == 1) begin
        chk("d access mem_read", 32'(mem_read), 32'(!we));
        chk("d access mem_write", 32'(mem_write), 32'(we));
        chk("d access mem_addr", 32'(mem_addr), 32'(a));
        chk("d access mem_funct3", 32'(mem_funct3), 32'(f3));
      end
      if (lat == 2) chk("d resp strobes", 32'({mem_read, mem_write}), 32'd0);
      chk("d side if_ready quiet", 32'(if_ready), 32'd0);
    end
    rd = d_rdata;
    d_req = 1'b0;
    if (we) st_gold(a, f3, wd);
    step();
  endtask

  task automatic if_txn(input logic [7:0] a, output logic [31:0] rd, output int lat);
    if_req = 1'b1; if_addr = a;
    lat = 0;
    while (!if_ready && lat < 10) begin
      step();
      lat++;
      if (lat == 1) begin
        chk("if access mem_read", 32'(mem_read), 32'd1);
        chk("if access mem_write", 32'(mem_write), 32'd0);
        chk("if access mem_funct3", 32'(mem_funct3), 32'd2);
        chk("if access mem_addr", 32'(mem_addr), 32'(a));
      end
      chk("if side d_ready quiet", 32'(d_ready), 32'd0);
    end
    rd = if_rdata;
    if_req = 1'b0;
    step();
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [11];
    logic [31:0] rd, exp_if_rd, exp_d_rd;
    int          lat, dcyc, icyc, overlap, ng;
    logic [3:0]  order, exp_order;
    logic        rd_d, rd_i;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_funct3 = 3'b000; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) gold[i] = init_byte(i);

    // Reset values
    step();
    chk("reset readies", 32'({if_ready, d_ready}), 32'd0);
    chk("reset strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_funct3", 32'(mem_funct3), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Simultaneous requests held until ready
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h08; if_req = 1'b1; if_addr = 8'h04;
    dcyc = 0; icyc = 0; overlap = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      if (d_ready && if_ready) overlap++;
      if (d_ready) begin dcyc = cyc; d_req = 1'b0; chk("contend d_rdata", d_rdata, ld_gold(8'h08, 3'b010)); end
      if (if_ready) begin icyc = cyc; if_req = 1'b0; chk("contend if_rdata", if_rdata, ld_gold(8'h04, 3'b010)); end
    end
    chk("contend d_ready cycle", 32'(dcyc), 32'd2);
    chk("contend if_ready cycle", 32'(icyc), 32'd5);
    chk("contend overlap", 32'(overlap), 32'd0);

    // Both re-raised continuously for four grants
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    d_req = 1'b1; d_addr = 8'h40; d_funct3 = 3'b010; d_we = 1'b0; if_req = 1'b1; if_addr = 8'h44;
    ng = 0; order = 4'b0000; overlap = 0;
    for (int cyc = 0; cyc < 30 && ng < 4; cyc++) begin
      step();
      rd_d = d_ready; rd_i = if_ready;
      if (rd_d && rd_i) overlap++;
      if (rd_d) begin if (ng < 4) order[ng] = 1'b1; ng++; end
      if (rd_i) begin if (ng < 4) order[ng] = 1'b0; ng++; end
      d_req = !rd_d; if_req = !rd_i;
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
    chk("stream grant count", 32'(ng), 32'd4);
    chk("stream grant order", 32'(order), 32'(exp_order));
    chk("stream overlap", 32'(overlap), 32'd0);

    // Fetch of word 0
    if_txn(8'h00, rd, lat);
    chk("fetch addr0 rdata", rd, 32'd12);
    chk("fetch addr0 latency", 32'(lat), 32'd2);

    // Data-side vectors; a store leaves d_rdata at the previous load value
    vecs[0]  = '{1'b0, 3'b010, 8'h00, 32'h0,        32'h0000000C};
    vecs[1]  = '{1'b1, 3'b010, 8'h08, 32'hDEADBEEF, 32'h0000000C};
    vecs[2]  = '{1'b0, 3'b000, 8'h08, 32'h0,        32'hFFFFFFEF};
    vecs[3]  = '{1'b0, 3'b100, 8'h08, 32'h0,        32'h000000EF};
    vecs[4]  = '{1'b0, 3'b001, 8'h0A, 32'h0,        32'hFFFFDEAD};
    vecs[5]  = '{1'b0, 3'b101, 8'h0A, 32'h0,        32'h0000DEAD};
    vecs[6]  = '{1'b1, 3'b000, 8'h09, 32'h12345677, 32'h0000DEAD};
    vecs[7]  = '{1'b0, 3'b010, 8'h08, 32'h0,        32'hDEAD77EF};
    vecs[8]  = '{1'b1, 3'b001, 8'h0C, 32'hAAAA8001, 32'hDEAD77EF};
    vecs[9]  = '{1'b0, 3'b001, 8'h0C, 32'h0,        32'hFFFF8001};
    vecs[10] = '{1'b0, 3'b011, 8'h08, 32'h0,        32'h00000000};
    foreach (vecs[i]) begin
      d_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
    end
    chk("store word in memory", mem_word(8'h08), 32'hDEAD77EF);

    // Reset during the ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h20; d_wdata = 32'hAABBCCDD;
    step();
    chk("pre-reset mem_write", 32'(mem_write), 32'd1);
    #2;
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("mid-reset strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("mid-reset readies", 32'({if_ready, d_ready}), 32'd0);
    chk("mid-reset rdata", if_rdata | d_rdata, 32'd0);
    chk("mid-reset mem_addr", 32'(mem_addr), 32'd0);
    chk("mid-reset mem_wdata", mem_wdata, 32'd0);
    chk("mid-reset mem_funct3", 32'(mem_funct3), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("cancelled store memory", mem_word(8'h20), ld_gold(8'h20, 3'b010));
    exp_if_rd = ld_gold(8'h20, 3'b010);
    if_txn(8'h20, rd, lat);
    chk("post-reset fetch rdata", rd, exp_if_rd);
    chk("post-reset fetch latency", 32'(lat), 32'd2);

    // Inputs changed after acceptance must not affect the write
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 8'h30; d_wdata = 32'h11223344;
    step();
    d_addr = 8'h34; d_wdata = 32'h0;
    chk("latched mem_addr", 32'(mem_addr), 32'h30);
    chk("latched mem_wdata", mem_wdata, 32'h11223344);
    step();
    chk("latched store ready", 32'(d_ready), 32'd1);
    d_req = 1'b0;
    st_gold(8'h30, 3'b010, 32'h11223344);
    step();
    chk("latched store target", mem_word(8'h30), 32'h11223344);
    chk("latched store neighbour", mem_word(8'h34), ld_gold(8'h34, 3'b010));

    // Randomized traffic against a transaction-level model
    exp_d_rd = 32'd0;
    begin
      int          free_edge, pend_cyc, k;
      logic        pend, pend_own_d, pend_load, last_d, own_d, d_acc, i_acc, exp_dr, exp_ir;
      logic [31:0] pend_val;
      free_edge = 0; pend = 1'b0; pend_cyc = 0; pend_own_d = 1'b0; pend_load = 1'b0;
      pend_val = '0; last_d = 1'b0; d_acc = 1'b0; i_acc = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (c >= free_edge && (d_req || if_req)) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          own_d = (d_req && if_req) ? !last_d : d_req;
`else
          own_d = d_req;
`endif
          last_d = own_d;
          pend = 1'b1; pend_cyc = c + 1; pend_own_d = own_d; free_edge = c + 3;
          if (own_d) begin
            d_acc = 1'b1;
            pend_load = !d_we;
            if (d_we) st_gold(d_addr, d_funct3, d_wdata);
            else pend_val = ld_gold(d_addr, d_funct3);
          end else begin
            i_acc = 1'b1;
            pend_load = 1'b1;
            pend_val = ld_gold(if_addr, 3'b010);
          end
        end
        step();
        exp_dr = pend && pend_cyc == c && pend_own_d;
        exp_ir = pend && pend_cyc == c && !pend_own_d;
        if (pend && pend_cyc == c) begin
          if (pend_load && pend_own_d) exp_d_rd = pend_val;
          if (pend_load && !pend_own_d) exp_if_rd = pend_val;
          pend = 1'b0;
        end
        chk("rand d_ready", 32'(d_ready), 32'(exp_dr));
        chk("rand if_ready", 32'(if_ready), 32'(exp_ir));
        chk("rand d_rdata", d_rdata, exp_d_rd);
        chk("rand if_rdata", if_rdata, exp_if_rd);
        if (d_ready) begin
          d_req = 1'b0; d_acc = 1'b0;
        end else if (d_req && d_acc) begin
          d_addr = 8'($urandom); d_wdata = $urandom; d_we = 1'($urandom); d_funct3 = 3'($urandom);
        end else if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 8'($urandom); d_wdata = $urandom;
          k = int'($urandom_range(0, 4));
          if (d_we) d_funct3 = 3'($urandom_range(0, 2));
          else d_funct3 = (k < 3) ? 3'(k) : 3'(k + 1);
        end
        if (if_ready) begin
          if_req = 1'b0; i_acc = 1'b0;
        end else if (if_req && i_acc) begin
          if_addr = 8'($urandom);
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 8'($urandom_range(0, 63) * 4);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
